// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin share of one next-level cache port.
// Optional: define CACHE_ARB_EVICT_PRIO_EN to favour evict traffic.
module cache_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int ADDRBITS   = 32,
  parameter int DATABITS   = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [REQUESTERS-1:0]          req_valid,
  input  logic [REQUESTERS-1:0]          req_evict,
  input  logic [REQUESTERS-1:0]          req_write,
  input  logic [REQUESTERS*ADDRBITS-1:0] req_addr,
  input  logic [REQUESTERS*DATABITS-1:0] req_wdata,
  output logic [REQUESTERS-1:0]          req_done,
  output logic [DATABITS-1:0]            req_rdata,
  output logic [REQUESTERS-1:0]          grant,
  output logic                           busy,
  output logic                           nl_request,
  output logic                           nl_evict,
  output logic                           nl_write,
  output logic [ADDRBITS-1:0]            nl_addr,
  output logic [DATABITS-1:0]            nl_wdata,
  input  logic                           nl_done,
  input  logic [DATABITS-1:0]            nl_rdata
);

  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [REQUESTERS-1:0] ONE = {{(REQUESTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } state_t;

  state_t                  state;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           owner;
  logic [PW-1:0]           win;
  logic                    found;
  logic [REQUESTERS-1:0]   cand;
  logic [ADDRBITS-1:0]     addr_a  [REQUESTERS];
  logic [DATABITS-1:0]     wdata_a [REQUESTERS];

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_split
    assign addr_a[g]  = req_addr[g*ADDRBITS +: ADDRBITS];
    assign wdata_a[g] = req_wdata[g*DATABITS +: DATABITS];
  end

  // Candidate set: evicts shadow plain requests when prioritised.
  always_comb begin
`ifdef CACHE_ARB_EVICT_PRIO_EN
    cand = req_valid & req_evict;
    if (cand == '0) cand = req_valid;
`else
    cand = req_valid;
`endif
  end

  // Scan the candidates from ptr upward, wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      if (!found && cand[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      req_done   <= '0;
      req_rdata  <= '0;
      nl_request <= 1'b0;
      nl_evict   <= 1'b0;
      nl_write   <= 1'b0;
      nl_addr    <= '0;
      nl_wdata   <= '0;
    end else begin
      nl_request <= 1'b0;
      req_done   <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner      <= win;
            grant      <= ONE << win;
            nl_evict   <= req_evict[win];
            nl_write   <= req_write[win];
            nl_addr    <= addr_a[win];
            nl_wdata   <= wdata_a[win];
            nl_request <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (nl_done) begin
            req_done  <= ONE << owner;
            req_rdata <= nl_rdata;
            state     <= RESPOND;
          end else begin
            state <= WAIT;
          end
        end
        RESPOND: begin
          grant <= '0;
          busy  <= 1'b0;
          if (owner == PW'(REQUESTERS - 1)) ptr <= '0;
          else ptr <= owner + PW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scoreboard bench for cache_arbiter.
// Expected transactions are queued in predicted grant order.
module tb_cache_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_evict;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_done;
  logic [31:0] req_rdata;
  logic [1:0]  grant;
  logic        busy;
  logic        nl_request;
  logic        nl_evict;
  logic        nl_write;
  logic [31:0] nl_addr;
  logic [31:0] nl_wdata;
  logic        nl_done_r;
  logic        spur_done;
  logic        nl_done_w;
  logic [31:0] nl_rdata;

  assign nl_done_w = nl_done_r | spur_done;

  cache_arbiter #(
    .REQUESTERS(2),
    .ADDRBITS(32),
    .DATABITS(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_evict(req_evict),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_done(req_done),
    .req_rdata(req_rdata),
    .grant(grant),
    .busy(busy),
    .nl_request(nl_request),
    .nl_evict(nl_evict),
    .nl_write(nl_write),
    .nl_addr(nl_addr),
    .nl_wdata(nl_wdata),
    .nl_done(nl_done_w),
    .nl_rdata(nl_rdata)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  g;
    logic        ev;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nreq  = 0;
  int   nl_lat = 0;
  logic prev_req  = 1'b0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic expect_txn(input logic [1:0] g, input logic ev,
                            input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rd);
    exp_t e;
    e.g = g; e.ev = ev; e.wr = wr;
    e.addr = a; e.wdata = d; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int r, input logic ev, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid[r] = 1'b1;
    req_evict[r] = ev;
    req_write[r] = wr;
    req_addr[r*32 +: 32]  = a;
    req_wdata[r*32 +: 32] = d;
  endtask

  task automatic wait_done(input int n, input bit keep, output int bc);
    int cnt;
    logic [1:0] d;
    cnt = 0;
    bc  = 0;
    for (int c = 0; c < 300 && cnt < n; c++) begin
      @(negedge clock);
      if (busy) bc++;
      if (req_done != 2'b00) begin
        cnt++;
        d = req_done;
        @(posedge clock);
        #1;
        if (cnt == n) req_valid = 2'b00;
        else if (!keep) req_valid = req_valid & ~d;
      end
    end
    if (cnt < n) check("timeout", 64'(cnt), 64'(n));
  endtask

  // Next-level model: answers nl_request after nl_lat extra cycles.
  initial begin
    nl_done_r = 1'b0;
    nl_rdata  = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset && nl_request) begin
        for (int k = 0; k < nl_lat && reset; k++) begin
          @(posedge clock);
          #1;
        end
        if (reset) begin
          nl_done_r = 1'b1;
          nl_rdata  = (exp_q.size() > 0) ? exp_q[0].rdata : 32'h0;
          @(posedge clock);
          #1;
          nl_done_r = 1'b0;
        end
      end
    end
  end

  // Monitor: compare issued command and response against the queue.
  always @(negedge clock) begin
    exp_t e;
    if (nl_request) begin
      nreq++;
      check("nl_req_pulse", 64'(prev_req), 64'd0);
    end
    if (grant != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("grant_unexp", 64'(grant), 64'd0);
      end else begin
        check("grant", 64'(grant), 64'(exp_q[0].g));
        check("nl_addr", 64'(nl_addr), 64'(exp_q[0].addr));
        check("nl_evict", 64'(nl_evict), 64'(exp_q[0].ev));
        check("nl_write", 64'(nl_write), 64'(exp_q[0].wr));
        check("nl_wdata", 64'(nl_wdata), 64'(exp_q[0].wdata));
      end
    end
    if (req_done != 2'b00) begin
      check("done_lat", 64'(prev_done), 64'd1);
      if (exp_q.size() == 0) begin
        check("done_unexp", 64'(req_done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("req_done", 64'(req_done), 64'(e.g));
        check("req_rdata", 64'(req_rdata), 64'(e.rdata));
      end
    end
    prev_req  = nl_request;
    prev_done = nl_done_w;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int n0;
    reset     = 1'b1;
    spur_done = 1'b0;
    req_valid = '0;
    req_evict = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_done", 64'(req_done), 64'd0);
    check("rst_rdata", 64'(req_rdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_nlreq", 64'(nl_request), 64'd0);
    check("rst_nlev", 64'(nl_evict), 64'd0);
    check("rst_nlwr", 64'(nl_write), 64'd0);
    check("rst_nladdr", 64'(nl_addr), 64'd0);
    check("rst_nlwd", 64'(nl_wdata), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;

    // Single read, two WAIT cycles.
    nl_lat = 2;
    n0 = nreq;
    expect_txn(2'b01, 1'b0, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF);
    drive(0, 1'b0, 1'b0, 32'h1000, 32'h0);
    wait_done(1, 1'b0, bc);
    check("read_busy_cyc", 64'(bc), 64'd4);
    check("read_nreq", 64'(nreq - n0), 64'd1);

    // Command stability: address change and valid drop mid-WAIT.
    nl_lat = 4;
    expect_txn(2'b01, 1'b0, 1'b0, 32'h3000, 32'h0, 32'h33333333);
    drive(0, 1'b0, 1'b0, 32'h3000, 32'h0);
    repeat (3) @(negedge clock);
    #1;
    req_addr[31:0] = 32'h0000FFFF;
    req_valid[0]   = 1'b0;
    wait_done(1, 1'b0, bc);

    // Fast completion: nl_done during ISSUE.
    nl_lat = 0;
    expect_txn(2'b10, 1'b0, 1'b1, 32'h4000, 32'h12345678, 32'h0BADF00D);
    drive(1, 1'b0, 1'b1, 32'h4000, 32'h12345678);
    wait_done(1, 1'b0, bc);
    check("fast_busy_cyc", 64'(bc), 64'd2);

    // Spurious nl_done while IDLE.
    @(posedge clock);
    #1 spur_done = 1'b1;
    @(negedge clock);
    check("spur_done", 64'(req_done), 64'd0);
    check("spur_busy", 64'(busy), 64'd0);
    @(posedge clock);
    #1 spur_done = 1'b0;
    @(negedge clock);
    check("spur_done2", 64'(req_done), 64'd0);
    check("spur_busy2", 64'(busy), 64'd0);
    check("spur_grant", 64'(grant), 64'd0);

    // Fairness: both held for four transactions.
    @(posedge clock);
    #1;
    nl_lat = 1;
    expect_txn(2'b01, 1'b0, 1'b0, 32'h100, 32'h0, 32'hA1);
    expect_txn(2'b10, 1'b0, 1'b0, 32'h200, 32'h0, 32'hA2);
    expect_txn(2'b01, 1'b0, 1'b0, 32'h100, 32'h0, 32'hA3);
    expect_txn(2'b10, 1'b0, 1'b0, 32'h200, 32'h0, 32'hA4);
    drive(0, 1'b0, 1'b0, 32'h100, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h200, 32'h0);
    wait_done(4, 1'b1, bc);

    // Evict versus plain read in the same cycle, ptr = 0.
`ifdef CACHE_ARB_EVICT_PRIO_EN
    expect_txn(2'b10, 1'b1, 1'b1, 32'h2040, 32'hE1E1, 32'h66);
    expect_txn(2'b01, 1'b0, 1'b0, 32'h5000, 32'h0, 32'h55);
`else
    expect_txn(2'b01, 1'b0, 1'b0, 32'h5000, 32'h0, 32'h55);
    expect_txn(2'b10, 1'b1, 1'b1, 32'h2040, 32'hE1E1, 32'h66);
`endif
    drive(0, 1'b0, 1'b0, 32'h5000, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h2040, 32'hE1E1);
    wait_done(2, 1'b0, bc);
    req_evict = '0;
    req_write = '0;

    // Reset during WAIT.
    nl_lat = 10;
    expect_txn(2'b01, 1'b0, 1'b0, 32'h9000, 32'h0, 32'h99);
    drive(0, 1'b0, 1'b0, 32'h9000, 32'h0);
    repeat (4) @(negedge clock);
    check("mid_busy_pre", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_grant", 64'(grant), 64'd0);
    check("mid_nlreq", 64'(nl_request), 64'd0);
    check("mid_done", 64'(req_done), 64'd0);
    exp_q.delete();
    req_valid = '0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;

    // After reset: requester 1 alone, then both (ptr back to 0).
    nl_lat = 1;
    expect_txn(2'b10, 1'b0, 1'b0, 32'h6000, 32'h0, 32'h60);
    drive(1, 1'b0, 1'b0, 32'h6000, 32'h0);
    wait_done(1, 1'b0, bc);
    expect_txn(2'b01, 1'b0, 1'b0, 32'h7000, 32'h0, 32'h70);
    expect_txn(2'b10, 1'b0, 1'b0, 32'h7100, 32'h0, 32'h71);
    drive(0, 1'b0, 1'b0, 32'h7000, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h7100, 32'h0);
    wait_done(2, 1'b0, bc);

    repeat (3) @(negedge clock);
    check("q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
